// File: rtl/pdm_pkg.sv
// Shared PDM definitions: default timing, data widths and control state
// encoding. The PDM microphone receiver uses this package as well.
package pdm_pkg;

  localparam int CLK_DIV_DEF = 25;  // clk cycles per m_clk half-period
  localparam int OSR_DEF     = 64;  // PDM bits per PCM sample
  localparam int SAMPLE_W    = 8;   // PCM sample width
  localparam int ACC_W       = 8;   // sigma-delta accumulator width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdm_sigma_delta.sv
// First-order sigma-delta core. The carry of acc + sample is the next PDM
// bit; the low bits are kept as the running error, advanced once per bit event.
module pdm_sigma_delta
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ACC_W-1:0] sample,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, sample};
  assign carry = sum[ACC_W];

  // Error accumulator: flushed on reset/stop, never at sample boundaries.
  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (adv)
      acc <= sum[ACC_W-1:0];
  end

endmodule

// File: rtl/pdm_transmitter.sv
// PCM to PDM transmitter: divides clk down to m_clk, emits one modulator bit
// per m_clk falling edge and swaps in a buffered sample every OSR bits.
module pdm_transmitter
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int OSR     = OSR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                m_clk,
  output logic                M_DATA,
  output logic                underflow
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  pdm_state_t          state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] nxt;
  logic                nxt_valid;
  logic                running;
  logic                wrap;
  logic                bit_ev;
  logic                boundary;
  logic                hs;
  logic                sd_clr;
  logic                sd_carry;

  // One-entry skid: the source may refill nxt whenever it is empty.
  assign s_ready  = !nxt_valid;
  assign hs       = s_valid && s_ready;
  assign running  = (state == RUN) && en;
  assign wrap     = running && (div_cnt == DIV_LAST);
  // A bit event is the wrap that takes m_clk low, so M_DATA settles half a
  // period before the receiver samples it on the rising edge.
  assign bit_ev   = wrap && m_clk;
  assign boundary = bit_ev && (bit_cnt == BIT_LAST);
  assign sd_clr   = !en;

  pdm_sigma_delta u_sd (
    .clk    (clk),
    .rst    (rst),
    .clr    (sd_clr),
    .adv    (bit_ev),
    .sample (cur),
    .carry  (sd_carry)
  );

  // Control FSM: divider, bit counter, current sample and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cur       <= '0;
      m_clk     <= 1'b0;
      M_DATA    <= 1'b0;
      underflow <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cur       <= '0;
      m_clk     <= 1'b0;
      M_DATA    <= 1'b0;
      underflow <= 1'b0;
    end else if (state == IDLE) begin
      // Counters are already zero here; this cycle only arms the divider.
      state     <= RUN;
      underflow <= 1'b0;
    end else begin
      underflow <= boundary && !nxt_valid;
      if (wrap) begin
        div_cnt <= '0;
        m_clk   <= !m_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (bit_ev) begin
        M_DATA  <= sd_carry;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
      // On underflow cur is simply held, repeating the last density.
      if (boundary && nxt_valid)
        cur <= nxt;
    end
  end

  // Input buffer: survives en=0, drained only at a boundary, lost on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt       <= '0;
      nxt_valid <= 1'b0;
    end else if (boundary && nxt_valid) begin
      nxt_valid <= 1'b0;
    end else if (hs) begin
      nxt       <= s_data;
      nxt_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdm_transmitter.sv
// Directed bench for pdm_transmitter with a bit-level scoreboard monitor.
module tb_pdm_transmitter;

  localparam int CLK_DIV = 25;
  localparam int OSR     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       m_clk;
  logic       M_DATA;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_transmitter #(.CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_clk     (m_clk),
    .M_DATA    (M_DATA),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference monitor ----------------
  typedef struct {
    logic [7:0]  cur;
    logic [63:0] bits;
    int          ones;
  } win_t;

  win_t        win_log[$];
  logic [7:0]  pend_q[$];   // accepted samples not yet in use (the nxt slot)
  logic [7:0]  mcur = '0;
  logic [7:0]  macc = '0;
  logic [7:0]  dat_p = '0;
  logic [8:0]  msum;
  logic [63:0] mwin_exp = '0;
  logic [63:0] mwin_dut = '0;
  int          mbit = 0;
  int          bnd_cnt = 0;
  int          uf_seen = 0;
  int          uf_exp = 0;
  logic        rst_p = 1'b1;
  logic        en_p = 1'b0;
  logic        hs_p = 1'b0;
  logic        mclk_prev = 1'b0;
  win_t        wtmp;

  // Runs on the falling clk edge: applies what the DUT saw at the previous
  // rising edge, then latches the inputs it will see at the next one.
  always @(negedge clk) begin
    if (rst_p) begin
      pend_q.delete();
      macc = '0; mcur = '0; mbit = 0; mwin_exp = '0; mwin_dut = '0;
    end else begin
      if (!en_p) begin
        macc = '0; mcur = '0; mbit = 0; mwin_exp = '0; mwin_dut = '0;
      end else if (mclk_prev && !m_clk) begin
        msum     = {1'b0, macc} + {1'b0, mcur};
        macc     = msum[7:0];
        mwin_exp = {mwin_exp[62:0], msum[8]};
        mwin_dut = {mwin_dut[62:0], M_DATA};
        mbit++;
        if (mbit == OSR) begin
          chk("window_bits", mwin_dut, mwin_exp);
          chk("boundary_underflow", underflow, pend_q.size() == 0);
          if (pend_q.size() == 0) uf_exp++;
          wtmp.cur  = mcur;
          wtmp.bits = mwin_dut;
          wtmp.ones = $countones(mwin_dut);
          win_log.push_back(wtmp);
          if (pend_q.size() > 0) mcur = pend_q.pop_front();
          mbit = 0;
          bnd_cnt++;
        end
      end
      if (hs_p) pend_q.push_back(dat_p);
    end
    chk("s_ready", s_ready, pend_q.size() == 0);
    if (underflow === 1'b1) uf_seen++;
    mclk_prev = m_clk;
    rst_p     = rst;
    en_p      = en;
    hs_p      = s_valid && s_ready;
    dat_p     = s_data;
  end

  function automatic int win_ones(input int i);
    return (i >= 0 && i < win_log.size()) ? win_log[i].ones : -1;
  endfunction

  function automatic logic [63:0] win_bits(input int i);
    return (i >= 0 && i < win_log.size()) ? win_log[i].bits : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic push(input logic [7:0] d, input bit keep);
    logic rdy;
    int   n;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 8000);
    chk("push_accept", rdy, 1'b1);
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_bnd(input int target);
    int n;
    n = 0;
    while (bnd_cnt < target && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("boundary_wait", bnd_cnt >= target, 1'b1);
  endtask

  // Caller has just made en sampled-high possible at the next edge (edge 0).
  task automatic start_timing(input string tag);
    int   edges[$];
    logic prev;
    @(posedge clk); #1;
    prev = m_clk;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (m_clk !== prev) edges.push_back(n);
      prev = m_clk;
    end
    for (int i = 0; i < 4; i++)
      chk(tag, (edges.size() > i) ? edges[i] : -1, (i + 1) * CLK_DIV);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, uf0, n0, w0, k, i255, i0, sum, n;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_clk", m_clk, 1'b0);
    chk("rst_m_data", M_DATA, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Preloaded 128: first window silent, then 0101...
    push(8'd128, 1'b0);
    chk("preload_s_ready", s_ready, 1'b0);
    en = 1'b1;
    start_timing("start_timing");
    wait_bnd(2);
    chk("win0_zero", win_bits(0), 64'h0);
    chk("win1_alternate", win_bits(1), 64'h5555_5555_5555_5555);

    // Streamed 0 and 255 x4, then 64 held through underflow
    push(8'd0, 1'b0);
    repeat (4) push(8'd255, 1'b0);
    push(8'd64, 1'b0);
    wait_bnd(bnd_cnt + 1);
    b0 = bnd_cnt; uf0 = uf_seen; n0 = win_log.size();
    wait_bnd(b0 + 3);
    chk("hold_underflow_count", uf_seen - uf0, 3);
    for (int i = 0; i < 3; i++) chk("hold_density", win_ones(n0 + i), 16);
    i255 = -1; i0 = -1;
    for (int i = 0; i < win_log.size(); i++) begin
      if (i255 < 0 && win_log[i].cur == 8'd255) i255 = i;
      if (i0 < 0 && i >= 2 && win_log[i].cur == 8'd0) i0 = i;
    end
    sum = 0;
    for (int i = 0; i < 4; i++) sum += win_ones((i255 < 0) ? -1 : i255 + i);
    chk("density_255x4", sum, 255);
    chk("density_0", win_ones(i0), 0);

    // Backpressure with s_valid held high
    push(8'd4, 1'b1);
    w0 = win_log.size();
    chk("bp_ready_drop", s_ready, 1'b0);
    push(8'd8, 1'b1);
    push(8'd12, 1'b1);
    push(8'd16, 1'b0);
    wait_bnd(bnd_cnt + 1);
    chk("bp_order_4", win_ones(w0 + 1), 1);
    chk("bp_order_8", win_ones(w0 + 2), 2);
    chk("bp_order_12", win_ones(w0 + 3), 3);

    // Reset pulse at bit 30 with a sample buffered
    push(8'd20, 1'b0);
    n = 0;
    while (!(mbit == 30 && m_clk === 1'b1) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bit30_wait", mbit, 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_m_clk", m_clk, 1'b0);
    chk("midrst_m_data", M_DATA, 1'b0);
    chk("midrst_underflow", underflow, 1'b0);
    chk("midrst_s_ready", s_ready, 1'b1);
    start_timing("rst_restart_timing");

    // en dropped mid-sample with nxt buffered, then raised
    push(8'd32, 1'b0);
    push(8'd96, 1'b0);
    n = 0;
    while (!(mbit >= 20 && m_clk === 1'b1 && M_DATA === 1'b1) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("en_drop_point", {m_clk, M_DATA}, 2'b11);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en_off_m_clk", m_clk, 1'b0);
    chk("en_off_m_data", M_DATA, 1'b0);
    chk("en_off_nxt_kept", s_ready, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("en_off_nxt_still", s_ready, 1'b0);
    k = win_log.size();
    b0 = bnd_cnt;
    en = 1'b1;
    start_timing("en_restart_timing");
    wait_bnd(b0 + 2);
    chk("restart_first_window", win_ones(k), 0);
    chk("restart_nxt_used", win_ones(k + 1), 24);

    chk("underflow_total", uf_seen, uf_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_transmitter.md
PDM_TRANSMITTER -- requirements
Module: pdm_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per m_clk half-period (100 MHz clk gives a 2 MHz m_clk).
REQ-002 Parameter OSR, default 64: PDM bits emitted per input sample.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; low means stop and flush.
REQ-006 s_data  input  8  unsigned PCM sample; 0 means zero density, 255 means 255/256 density.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 m_clk  output  1  PDM bit clock to the external receiver or amplifier.
REQ-010 M_DATA  output  1  PDM bitstream; stable around every m_clk rising edge.
REQ-011 underflow  output  1  one-cycle pulse: sample boundary reached with no new sample buffered.

Function
REQ-012 Divider counter runs 0..CLK_DIV-1 while en=1.
- m_clk toggles on each wrap.
- First rising edge of m_clk occurs CLK_DIV cycles after en is first sampled high.
- First falling edge occurs 2*CLK_DIV cycles after en is first sampled high.
REQ-013 Bit event: the clk cycle in which m_clk toggles 1->0.
- M_DATA, the accumulator and bit_cnt update only on bit events.
REQ-014 Modulator: first-order sigma-delta.
- 8-bit accumulator; {carry, acc} <= acc + cur (9-bit sum).
- M_DATA <= carry on each bit event.
REQ-015 Buffering: two sample registers.
- cur: sample in use by the modulator.
- nxt: one-entry buffer with flag nxt_valid.
- s_ready = !nxt_valid, combinational.
- Handshake (s_valid && s_ready) loads nxt and sets nxt_valid.
REQ-016 bit_cnt counts 0..OSR-1 and increments on each bit event.
REQ-017 Sample boundary: a bit event with bit_cnt==OSR-1.
- If nxt_valid: cur <= nxt and nxt_valid clears.
- If not nxt_valid: cur is held and underflow pulses for that cycle.
REQ-018 Handshake in the same cycle as a boundary with nxt empty:
- Data goes to nxt, not cur.
- underflow still pulses.
- The new data is used at the next boundary.
REQ-019 Accumulator is never cleared at sample boundaries; error carries across samples.
REQ-020 en deasserted: on the next edge, clear divider, bit_cnt, acc, cur, m_clk and M_DATA.
- nxt and nxt_valid are retained.
- s_ready keeps following REQ-015.
REQ-021 en reasserted: timing restarts exactly as in REQ-012.
- cur is 0 until the first boundary, so the first OSR bits are 0.
REQ-022 State machine has two states, IDLE and RUN.
- IDLE -> RUN when en=1.
- RUN -> IDLE when en=0.
- rst forces IDLE.

Reset
REQ-023 rst has priority over en and handshake, and clears every register.
- Cleared: divider, bit_cnt, acc, cur, nxt, nxt_valid, state, m_clk, M_DATA, underflow.
REQ-024 Output values during and after reset: m_clk=0, M_DATA=0, underflow=0, s_ready=1.
REQ-025 Reset asserted mid-sample takes effect on the next edge.
- No partial bit is emitted.
- Any buffered sample is discarded.

Structure
REQ-026 Shared package pdm_pkg holds:
- CLK_DIV and OSR defaults.
- Sample width (8) and accumulator width (8).
- The state encoding (IDLE, RUN).
- The package is shared with the existing PDM microphone receiver.
REQ-027 One sub-module, pdm_sigma_delta: accumulator and carry output, advanced by a bit-event enable.
- Divider, buffering and control stay in pdm_transmitter.

Verification
REQ-028 Sample 128 pre-loaded, en=1, CLK_DIV=25, OSR=64:
- m_clk period is exactly 50 clk cycles.
- M_DATA is all 0 for the first 64 bits.
- From the second sample onward, M_DATA alternates 0,1,0,1.
REQ-029 Samples 0 and 255 streamed continuously:
- Sample 0 gives 0 ones in its 64-bit window.
- Sample 255 gives 255 ones over 256 consecutive bits (4 samples of 255).
REQ-030 One sample supplied, then s_valid=0:
- underflow pulses exactly once at each following 64th bit event.
- cur is held, so the M_DATA density is unchanged.
REQ-031 Backpressure: s_valid held high with incrementing data.
- s_ready drops after one accept.
- s_ready reasserts the cycle after each boundary.
- No sample is lost or duplicated.
REQ-032 rst pulsed for 1 cycle at bit 30 of a sample:
- All outputs read 0 on the next cycle; s_ready=1.
- Restart timing matches REQ-012.
REQ-033 en dropped mid-sample, then raised:
- m_clk and M_DATA go to 0.
- The buffered nxt sample is used at the first boundary after the restart.
